// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: decoder control bundle into the pipeline and per-stage control outputs.
interface ctrl_pipe_if #(parameter int RW = 5, parameter int AOPW = 3);
  logic            id_valid, id_legal;
  logic            id_RegDs, id_Branch, id_MRead, id_MtoR, id_MWrite, id_ALUsrc, id_Urw;
  logic [AOPW-1:0] id_AOp;
  logic [RW-1:0]   id_rs, id_rt, id_rd;
  logic            ex_zero;
  logic            ex_RegDs, ex_ALUsrc;
  logic [AOPW-1:0] ex_AOp;
  logic            mem_Branch, mem_MRead, mem_MWrite;
  logic            wb_MtoR, wb_Urw;
  logic [RW-1:0]   ex_dst, mem_dst, wb_dst;
  logic            pc_src, stall, flush, illegal;
  modport master (
    output id_valid, id_legal, id_RegDs, id_Branch, id_MRead, id_MtoR, id_MWrite, id_ALUsrc,
           id_Urw, id_AOp, id_rs, id_rt, id_rd, ex_zero,
    input  ex_RegDs, ex_ALUsrc, ex_AOp, mem_Branch, mem_MRead, mem_MWrite, wb_MtoR, wb_Urw,
           ex_dst, mem_dst, wb_dst, pc_src, stall, flush, illegal
  );
  modport slave (
    input  id_valid, id_legal, id_RegDs, id_Branch, id_MRead, id_MtoR, id_MWrite, id_ALUsrc,
           id_Urw, id_AOp, id_rs, id_rt, id_rd, ex_zero,
    output ex_RegDs, ex_ALUsrc, ex_AOp, mem_Branch, mem_MRead, mem_MWrite, wb_MtoR, wb_Urw,
           ex_dst, mem_dst, wb_dst, pc_src, stall, flush, illegal
  );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries sanitised decoder controls through ID/EX, EX/MEM, MEM/WB with load-use stall and branch flush.
module ctrl_pipe #(
  parameter int RW   = 5,
  parameter int AOPW = 3
) (
  input logic       clk,
  input logic       rst,
  ctrl_pipe_if.slave p
);
  typedef struct packed {
    logic            valid, reg_ds, branch, mread, mtor, mwrite, alusrc, urw;
    logic [AOPW-1:0] aop;
    logic [RW-1:0]   dst;
  } ex_t;
  typedef struct packed {
    logic          branch, mread, mtor, mwrite, urw, zero;
    logic [RW-1:0] dst;
  } mem_t;
  typedef struct packed {
    logic          mtor, urw;
    logic [RW-1:0] dst;
  } wb_t;
  ex_t           ex_q, ex_d;
  mem_t          mem_q, mem_d;
  wb_t           wb_q, wb_d;
  logic          illegal_q, illegal_d;
  logic          pc_src, hazard, stall, accept;
  logic [RW-1:0] id_dst;
  always_comb begin
    pc_src    = mem_q.branch & mem_q.zero;
    // rt is a source only for stores/branches (no write) or R-type (writes rd)
    hazard    = ex_q.valid & ex_q.mread & (ex_q.dst != '0) &
                ((ex_q.dst == p.id_rs) | ((ex_q.dst == p.id_rt) & (~p.id_Urw | p.id_RegDs)));
    stall     = p.id_valid & hazard & ~pc_src;
    accept    = p.id_valid & p.id_legal & ~stall & ~pc_src;
    id_dst    = p.id_Urw ? (p.id_RegDs ? p.id_rd : p.id_rt) : '0;
    ex_d      = accept ? ex_t'{valid: 1'b1, reg_ds: p.id_RegDs & p.id_Urw, branch: p.id_Branch,
                               mread: p.id_MRead, mtor: p.id_MtoR & p.id_Urw, mwrite: p.id_MWrite,
                               alusrc: p.id_ALUsrc, urw: p.id_Urw & (id_dst != '0),
                               aop: p.id_AOp, dst: id_dst} : '0;
    mem_d     = pc_src ? '0 : mem_t'{branch: ex_q.branch, mread: ex_q.mread, mtor: ex_q.mtor,
                                     mwrite: ex_q.mwrite, urw: ex_q.urw, zero: p.ex_zero,
                                     dst: ex_q.dst};
    wb_d      = wb_t'{mtor: mem_q.mtor, urw: mem_q.urw, dst: mem_q.dst};
    illegal_d = p.id_valid & ~p.id_legal & ~stall & ~pc_src;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      illegal_q <= illegal_d;
    end
  end
  assign p.ex_RegDs   = ex_q.reg_ds;
  assign p.ex_AOp     = ex_q.aop;
  assign p.ex_ALUsrc  = ex_q.alusrc;
  assign p.ex_dst     = ex_q.dst;
  assign p.mem_Branch = mem_q.branch;
  assign p.mem_MRead  = mem_q.mread;
  assign p.mem_MWrite = mem_q.mwrite;
  assign p.mem_dst    = mem_q.dst;
  assign p.wb_MtoR    = wb_q.mtor;
  assign p.wb_Urw     = wb_q.urw;
  assign p.wb_dst     = wb_q.dst;
  assign p.pc_src     = pc_src;
  assign p.flush      = pc_src;
  assign p.stall      = stall;
  assign p.illegal    = illegal_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed scenarios plus random instruction streams checked against an instruction-level pipeline model.
module tb_ctrl_pipe;
  typedef enum int {NONE, R, LW, SW, BEQ, ADDI, ILL} op_t;
  typedef struct {
    op_t        op;
    logic [4:0] rs, rt, rd;
    logic [9:0] j;
    logic       zero;
  } minst_t;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails = 0;
  always #5 clk = ~clk;
  ctrl_pipe_if #(.RW(5), .AOPW(3)) p();
  ctrl_pipe #(.RW(5), .AOPW(3)) dut (.clk(clk), .rst(rst), .p(p));
  wire [28:0] all_o = {p.ex_RegDs, p.ex_AOp, p.ex_ALUsrc, p.mem_Branch, p.mem_MRead, p.mem_MWrite,
                       p.wb_MtoR, p.wb_Urw, p.ex_dst, p.mem_dst, p.wb_dst,
                       p.pc_src, p.stall, p.flush, p.illegal};
  function automatic minst_t mk(op_t op, int rs, int rt, int rd);
    minst_t m;
    m.op = op; m.rs = 5'(rs); m.rt = 5'(rt); m.rd = 5'(rd);
    m.j = 10'($urandom); m.zero = 1'b0;
    return m;
  endfunction
  function automatic minst_t rnd();
    op_t ops[10] = '{NONE, R, R, R, LW, LW, SW, BEQ, ADDI, ILL};
    return mk(ops[$urandom % 10], int'($urandom % 4), int'($urandom % 4), int'($urandom % 4));
  endfunction
  function automatic logic [4:0] mdst(minst_t m);
    return m.op == R ? m.rd : (m.op == LW || m.op == ADDI) ? m.rt : 5'd0;
  endfunction
  function automatic logic [2:0] maop(op_t o);
    return o == R ? 3'b010 : o == BEQ ? 3'b001 : 3'b000;
  endfunction
  function automatic logic rtsrc(minst_t m);
    return (m.op inside {R, SW, BEQ}) || (m.op == ILL && (!m.j[6] || m.j[0]));
  endfunction
  // unused decoder fields get garbage from m.j; ILL/NONE get garbage everywhere
  task automatic drive(minst_t m);
    logic dc, ill;
    dc  = m.op inside {SW, BEQ, ILL, NONE};
    ill = m.op inside {ILL, NONE};
    p.id_valid  = m.op != NONE;
    p.id_legal  = m.op != ILL;
    p.id_RegDs  = (m.op == R) | (dc & m.j[0]);
    p.id_MtoR   = (m.op == LW) | (dc & m.j[1]);
    p.id_Branch = (m.op == BEQ) | (ill & m.j[2]);
    p.id_MRead  = (m.op == LW) | (ill & m.j[3]);
    p.id_MWrite = (m.op == SW) | (ill & m.j[4]);
    p.id_ALUsrc = (m.op inside {LW, SW, ADDI}) | (ill & m.j[5]);
    p.id_Urw    = (m.op inside {R, LW, ADDI}) | (ill & m.j[6]);
    p.id_AOp    = ill ? m.j[9:7] : maop(m.op);
    p.id_rs = m.rs; p.id_rt = m.rt; p.id_rd = m.rd;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1; p.ex_zero = 1'b0; drive(mk(NONE, 0, 0, 0));
    tick; tick; rst = 1'b0; #1;
    checks++; if (all_o !== '0) begin fails++; $display("FAIL reset_init got=%h exp=0", all_o); end
    drive(mk(SW, 1, 2, 0)); tick;
    drive(mk(LW, 3, 8, 0)); tick;
    drive(mk(R, 8, 2, 9)); #1;
    checks++; if ({p.mem_MWrite, p.stall, p.ex_dst} !== {1'b1, 1'b1, 5'd8}) begin
      fails++; $display("FAIL reset_preload got=%b exp=%b", {p.mem_MWrite, p.stall, p.ex_dst}, {1'b1, 1'b1, 5'd8}); end
    rst = 1'b1; tick; rst = 1'b0; drive(mk(NONE, 0, 0, 0)); #1;
    checks++; if (all_o !== '0) begin fails++; $display("FAIL reset_mid got=%h exp=0", all_o); end
  endtask
  task automatic test_rtype;
    drive(mk(R, 1, 2, 9)); tick; drive(mk(NONE, 0, 0, 0)); #1;
    checks++; if ({p.ex_RegDs, p.ex_AOp, p.ex_dst} !== {1'b1, 3'b010, 5'd9}) begin
      fails++; $display("FAIL rtype_ex got=%b exp=%b", {p.ex_RegDs, p.ex_AOp, p.ex_dst}, {1'b1, 3'b010, 5'd9}); end
    tick;
    checks++; if ({p.mem_Branch, p.mem_MRead, p.mem_MWrite, p.mem_dst} !== {3'b000, 5'd9}) begin
      fails++; $display("FAIL rtype_mem got=%b exp=%b", {p.mem_Branch, p.mem_MRead, p.mem_MWrite, p.mem_dst}, {3'b000, 5'd9}); end
    tick;
    checks++; if ({p.wb_Urw, p.wb_MtoR, p.wb_dst} !== {1'b1, 1'b0, 5'd9}) begin
      fails++; $display("FAIL rtype_wb got=%b exp=%b", {p.wb_Urw, p.wb_MtoR, p.wb_dst}, {1'b1, 1'b0, 5'd9}); end
  endtask
  task automatic test_load_use;
    drive(mk(LW, 3, 8, 0)); tick; drive(mk(R, 8, 5, 10)); #1;
    checks++; if (p.stall !== 1'b1) begin fails++; $display("FAIL lu_stall got=%b exp=1", p.stall); end
    tick;
    checks++; if ({p.stall, p.ex_dst, p.ex_RegDs, p.mem_MRead} !== {1'b0, 5'd0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL lu_bubble got=%b exp=%b", {p.stall, p.ex_dst, p.ex_RegDs, p.mem_MRead}, {1'b0, 5'd0, 1'b0, 1'b1}); end
    tick; drive(mk(NONE, 0, 0, 0)); #1;
    checks++; if ({p.ex_dst, p.ex_RegDs} !== {5'd10, 1'b1}) begin
      fails++; $display("FAIL lu_late got=%b exp=%b", {p.ex_dst, p.ex_RegDs}, {5'd10, 1'b1}); end
    drive(mk(LW, 3, 8, 0)); tick; drive(mk(R, 7, 6, 11)); #1;
    checks++; if (p.stall !== 1'b0) begin fails++; $display("FAIL lu_nostall got=%b exp=0", p.stall); end
    tick; drive(mk(LW, 3, 8, 0)); #1;
    checks++; if (p.ex_dst !== 5'd11) begin fails++; $display("FAIL lu_noslip got=%0d exp=11", p.ex_dst); end
    tick; drive(mk(SW, 1, 8, 0)); #1;
    checks++; if (p.stall !== 1'b1) begin fails++; $display("FAIL lu_store_rt got=%b exp=1", p.stall); end
    drive(mk(ADDI, 1, 8, 0)); #1;
    checks++; if (p.stall !== 1'b0) begin fails++; $display("FAIL lu_addi_rt got=%b exp=0", p.stall); end
    drive(mk(NONE, 0, 0, 0)); tick; tick; tick;
  endtask
  task automatic test_branch;
    p.ex_zero = 1'b0; drive(mk(BEQ, 1, 2, 0)); tick;
    p.ex_zero = 1'b1; drive(mk(SW, 4, 5, 0)); tick;
    p.ex_zero = 1'b0; drive(mk(R, 6, 7, 12)); #1;
    checks++; if ({p.pc_src, p.flush, p.stall} !== 3'b110) begin
      fails++; $display("FAIL br_taken got=%b exp=110", {p.pc_src, p.flush, p.stall}); end
    tick; drive(mk(NONE, 0, 0, 0)); #1;
    checks++; if ({p.pc_src, p.mem_MWrite, p.mem_dst, p.ex_dst} !== 12'd0) begin
      fails++; $display("FAIL br_squash got=%b exp=0", {p.pc_src, p.mem_MWrite, p.mem_dst, p.ex_dst}); end
    tick;
    checks++; if ({p.wb_Urw, p.wb_dst, p.mem_MWrite} !== 7'd0) begin
      fails++; $display("FAIL br_wb got=%b exp=0", {p.wb_Urw, p.wb_dst, p.mem_MWrite}); end
  endtask
  task automatic test_branch_hazard;
    drive(mk(BEQ, 1, 2, 0)); tick;
    p.ex_zero = 1'b1; drive(mk(LW, 3, 8, 0)); tick;
    p.ex_zero = 1'b0; drive(mk(R, 8, 1, 13)); #1;
    checks++; if ({p.stall, p.flush} !== 2'b01) begin
      fails++; $display("FAIL brhz_prio got=%b exp=01", {p.stall, p.flush}); end
    tick; drive(mk(NONE, 0, 0, 0)); #1;
    checks++; if ({p.ex_dst, p.mem_MRead, p.pc_src} !== 7'd0) begin
      fails++; $display("FAIL brhz_squash got=%b exp=0", {p.ex_dst, p.mem_MRead, p.pc_src}); end
    tick; tick;
  endtask
  task automatic test_illegal_sanitise;
    minst_t m;
    drive(mk(ILL, 1, 2, 3)); tick; drive(mk(NONE, 0, 0, 0)); #1;
    checks++; if ({p.illegal, p.ex_dst, p.ex_AOp, p.ex_RegDs, p.ex_ALUsrc} !== {1'b1, 10'd0}) begin
      fails++; $display("FAIL ill_pulse got=%b exp=%b", {p.illegal, p.ex_dst, p.ex_AOp, p.ex_RegDs, p.ex_ALUsrc}, {1'b1, 10'd0}); end
    tick;
    checks++; if (p.illegal !== 1'b0) begin fails++; $display("FAIL ill_once got=%b exp=0", p.illegal); end
    m = mk(SW, 1, 4, 13); m.j = '1; drive(m); tick; drive(mk(NONE, 0, 0, 0)); #1;
    checks++; if ({p.ex_RegDs, p.ex_dst} !== 6'd0) begin
      fails++; $display("FAIL sw_ex got=%b exp=0", {p.ex_RegDs, p.ex_dst}); end
    tick; tick;
    checks++; if ({p.wb_MtoR, p.wb_Urw, p.wb_dst} !== 7'd0) begin
      fails++; $display("FAIL sw_wb got=%b exp=0", {p.wb_MtoR, p.wb_Urw, p.wb_dst}); end
    drive(mk(ADDI, 1, 0, 0)); tick; drive(mk(NONE, 0, 0, 0)); tick; tick;
    checks++; if ({p.wb_Urw, p.wb_dst} !== 6'd0) begin
      fails++; $display("FAIL addi_r0 got=%b exp=0", {p.wb_Urw, p.wb_dst}); end
  endtask
  task automatic test_random;
    minst_t id, mex, mmem, mwb, bub;
    logic mill, taken, est, eacc, z;
    logic [4:0] d;
    logic [3:0] eh;
    logic [9:0] ee;
    logic [7:0] em;
    logic [6:0] ew;
    bub = mk(NONE, 0, 0, 0); mex = bub; mmem = bub; mwb = bub; mill = 1'b0;
    rst = 1'b1; drive(bub); tick; rst = 1'b0;
    id = rnd();
    for (int c = 0; c < 400; c++) begin
      z = 1'($urandom); drive(id); p.ex_zero = z; #1;
      taken = mmem.op == BEQ && mmem.zero;
      d = mdst(mex);
      est = id.op != NONE && mex.op == LW && d != 0 && (d == id.rs || (rtsrc(id) && d == id.rt)) && !taken;
      eacc = (id.op inside {R, LW, SW, BEQ, ADDI}) && !est && !taken;
      eh = {taken, taken, est, mill};
      ee = {mex.op == R, maop(mex.op), mex.op inside {LW, SW, ADDI}, mdst(mex)};
      em = {mmem.op == BEQ, mmem.op == LW, mmem.op == SW, mdst(mmem)};
      ew = {mwb.op == LW, (mwb.op inside {R, LW, ADDI}) && mdst(mwb) != 0, mdst(mwb)};
      checks++; if ({p.pc_src, p.flush, p.stall, p.illegal} !== eh) begin
        fails++; $display("FAIL rnd_hazard cyc=%0d got=%b exp=%b", c, {p.pc_src, p.flush, p.stall, p.illegal}, eh); end
      checks++; if ({p.ex_RegDs, p.ex_AOp, p.ex_ALUsrc, p.ex_dst} !== ee) begin
        fails++; $display("FAIL rnd_ex cyc=%0d got=%b exp=%b", c, {p.ex_RegDs, p.ex_AOp, p.ex_ALUsrc, p.ex_dst}, ee); end
      checks++; if ({p.mem_Branch, p.mem_MRead, p.mem_MWrite, p.mem_dst} !== em) begin
        fails++; $display("FAIL rnd_mem cyc=%0d got=%b exp=%b", c, {p.mem_Branch, p.mem_MRead, p.mem_MWrite, p.mem_dst}, em); end
      checks++; if ({p.wb_MtoR, p.wb_Urw, p.wb_dst} !== ew) begin
        fails++; $display("FAIL rnd_wb cyc=%0d got=%b exp=%b", c, {p.wb_MtoR, p.wb_Urw, p.wb_dst}, ew); end
      mill = id.op == ILL && !est && !taken;
      mwb = mmem;
      if (taken) mmem = bub;
      else begin
        mmem = mex;
        mmem.zero = z;
      end
      mex = eacc ? id : bub;
      if (!est) id = rnd();
      tick;
    end
    drive(bub);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_rtype;
    test_load_use;
    test_branch;
    test_branch_hazard;
    test_illegal_sanitise;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Receiving end of the decoder's control bundle: latches RegDs/Branch/MRead/MtoR/AOp/MWrite/ALUsrc/Urw at the ID stage.
- Carries the bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS datapath, with stage-valid bits.
- Detects load-use hazards (stall plus bubble) and resolves branches in MEM (flush).
- Sanitises don't-care and illegal decoder outputs so that no X reaches a stage register.

Parameters:
- RW, 5, register-index width.
- AOPW, 3, ALU-op field width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds an instruction.
- id_legal  in  1  opcode is one the decoder supports; when 0, the control inputs are undefined.
- id_RegDs, id_Branch, id_MRead, id_MtoR, id_MWrite, id_ALUsrc, id_Urw  in  1 each  decoder controls.
- id_AOp  in  AOPW  decoder ALU op.
- id_rs, id_rt, id_rd  in  RW each  register fields of the ID instruction.
- ex_zero  in  1  ALU zero flag of the instruction in EX.
- ex_RegDs, ex_AOp[AOPW], ex_ALUsrc  out  EX-stage controls.
- mem_Branch, mem_MRead, mem_MWrite  out  1 each  MEM-stage controls.
- wb_MtoR, wb_Urw  out  1 each  WB-stage controls.
- ex_dst, mem_dst, wb_dst  out  RW each  destination register per stage.
- pc_src  out  1  take branch; combinational, equals mem_Branch & mem_zero.
- stall  out  1  hold PC and IF/ID this cycle; combinational.
- flush  out  1  squash IF/ID; combinational, equals pc_src.
- illegal  out  1  one-cycle pulse, registered, when an illegal instruction is dropped.

Behaviour:
- Reset:
  - All stage registers, valid bits, the dst fields, mem_zero and illegal clear to 0.
  - Consequently pc_src = stall = flush = 0.
  - rst during operation discards every in-flight instruction on that edge.
- Capture sanitisation at ID→EX:
  - Accepted instruction = id_valid & id_legal & ~stall & ~flush.
  - If id_Urw = 0, store RegDs = 0 and MtoR = 0.
  - If id_Urw = 1, store ex_dst = id_RegDs ? id_rd : id_rt; otherwise ex_dst = 0.
  - A destination of 0 forces the stored Urw = 0.
- Bubble: every control bit 0, dst 0, valid 0. A bubble is inserted into EX when no instruction is accepted.
- Advance:
  - EX→MEM and MEM→WB shift every cycle, never stalled.
  - mem_zero is captured from ex_zero on the EX→MEM edge.
  - Latency: controls reach the EX outputs 1 cycle after ID capture, MEM after 2, WB after 3.
- Load-use hazard: stall = id_valid & ex_valid & ex_MRead & (ex_dst ≠ 0) & (ex_dst == id_rs | (ex_dst == id_rt & ~id_ALUsrc-type)).
  - Exact rule: compare id_rt only when id_Urw = 0 (store/branch use rt as a source) or id_RegDs = 1.
  - Effect: exactly one bubble; the held instruction is accepted on the next cycle.
- Branch:
  - pc_src = mem_Branch & mem_zero.
  - When pc_src = 1, the ID instruction is not accepted (bubble into EX), and the EX instruction becomes a bubble in MEM (its control bits are zeroed on the EX→MEM edge).
  - flush = 1 on that cycle.
- Simultaneous events: flush has priority over stall; when pc_src = 1, stall is forced to 0.
- Illegal instruction: id_valid & ~id_legal & ~stall & ~flush → bubble inserted, illegal pulses on the next cycle.
- Back-to-back loads and branches in consecutive slots are handled by the same rules; there is no other state.

Test Plan:
- Reset: assert rst mid-stream with LW in EX and SW in MEM → next cycle every output is 0, stall = 0, pc_src = 0.
- R-type flow: id_RegDs = 1, Urw = 1, AOp = 3'b010, rd = 9 →
  - cycle+1: ex_AOp = 3'b010, ex_dst = 9.
  - cycle+2: mem controls all 0.
  - cycle+3: wb_Urw = 1, wb_dst = 9.
- Load-use: LW rt = 8, then ADD rs = 8 → stall = 1 for exactly 1 cycle, EX bubble, ADD appears in EX one cycle late. With rs = 7, rt = 6 → no stall.
- Branch taken: BEQ with ex_zero = 1 → two cycles later pc_src = flush = 1. The younger instructions in ID and EX become bubbles: no wb_Urw and no mem_MWrite from them.
- Branch plus hazard in the same cycle: BEQ taken in MEM while an LW/use pair sits in EX/ID → stall = 0, flush = 1.
- Illegal/sanitise:
  - id_legal = 0 → bubble, illegal = 1 for one cycle.
  - SW with id_RegDs = x, MtoR = x → ex_RegDs = 0, wb_MtoR = 0, wb_dst = 0.
  - ADDI with rt = 0 → wb_Urw = 0.
